// File: rtl/vx_perf_pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline performance counter block:
// counter index map, counter count and read-FSM state encoding.
package VX_perf_pkg;
  localparam int NUM_CTRS    = 11;
  localparam int CTR_LOAD    = 0;
  localparam int CTR_STORE   = 1;
  localparam int CTR_BRANCH  = 2;
  localparam int CTR_IBF     = 3;
  localparam int CTR_SCB     = 4;
  localparam int CTR_LSU     = 5;
  localparam int CTR_CSR     = 6;
  localparam int CTR_ALU     = 7;
  localparam int CTR_FPU     = 8;
  localparam int CTR_GPU     = 9;
  localparam int CTR_THREADS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RSP    = 2'd2
  } rd_state_e;
endpackage

// File: rtl/vx_perf_pipeline_ctrl_ctr.sv
// One live performance counter: wraps modulo 2^W with a sticky wrap flag.
// EN=0 ties the counter and its flag to zero.
module VX_perf_ctr #(
  parameter int W  = 44,
  parameter bit EN = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_ovf
);
  logic [W-1:0] r_cnt;
  logic         r_ovf;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, r_cnt} + {1'b0, i_inc};

  // clear wins over the increment in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !EN) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_cnt <= w_sum[W-1:0];
      if (w_sum[W]) r_ovf <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/vx_perf_pipeline_ctrl.sv
// Pipeline perf counters: 11 live counters, a snapshot shadow bank and a
// 3-state read port returning shadow values two cycles after acceptance.
module vx_perf_pipeline_ctrl
  import VX_perf_pkg::*;
#(
  parameter int CTR_BITS    = 44,
  parameter int NUM_THREADS = 4,
  parameter bit FPU_EN      = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cnt_en,
  input  logic                           clear,
  input  logic                           snapshot,
  input  logic                           ev_load,
  input  logic                           ev_store,
  input  logic                           ev_branch,
  input  logic                           ev_ibf,
  input  logic                           ev_scb,
  input  logic                           ev_lsu,
  input  logic                           ev_csr,
  input  logic                           ev_alu,
  input  logic                           ev_fpu,
  input  logic                           ev_gpu,
  input  logic [$clog2(NUM_THREADS):0]   ev_threads,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [3:0]                     req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [CTR_BITS-1:0]            rsp_data,
  output logic [NUM_CTRS-1:0]            ovf
);
  logic [CTR_THREADS-1:0]               w_ev;
  logic [NUM_CTRS-1:0][CTR_BITS-1:0]    w_live;
  logic [NUM_CTRS-1:0][CTR_BITS-1:0]    r_shadow;
  logic [CTR_BITS-1:0]                  w_sel;
  rd_state_e                            r_state;
  logic [3:0]                           r_addr;
  logic [CTR_BITS-1:0]                  r_rsp_data;
  logic                                 r_req_ready;
  logic                                 r_rsp_valid;

  assign w_ev = {ev_gpu, ev_fpu, ev_alu, ev_csr, ev_lsu,
                 ev_scb, ev_ibf, ev_branch, ev_store, ev_load};

  for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
    logic [CTR_BITS-1:0] w_inc;
    if (i == CTR_THREADS) begin : g_thr
      assign w_inc = CTR_BITS'(ev_threads);
    end else begin : g_ev
      assign w_inc = CTR_BITS'(w_ev[i]);
    end
    VX_perf_ctr #(
      .W  (CTR_BITS),
      .EN ((i != CTR_FPU) || FPU_EN)
    ) u_ctr (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clear (clear),
      .i_en    (cnt_en),
      .i_inc   (w_inc),
      .o_cnt   (w_live[i]),
      .o_ovf   (ovf[i])
    );
  end

  // shadow captures pre-edge live values; clear leaves it alone
  always_ff @(posedge clk) begin
    if (reset)         r_shadow <= '0;
    else if (snapshot) r_shadow <= w_live;
  end

  // unmapped addresses fall through to zero
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CTRS; i++)
      if (r_addr == 4'(i)) w_sel = r_shadow[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rsp_data  <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_addr      <= req_addr;
          r_state     <= ST_LOOKUP;
          r_req_ready <= 1'b0;
        end
        ST_LOOKUP: begin
          r_rsp_data  <= w_sel;
          r_state     <= ST_RSP;
          r_rsp_valid <= 1'b1;
        end
        ST_RSP: if (rsp_ready) begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
endmodule
